// File: rtl/maq_m_set.sv
// maq_m_set -- minute stage and time-set controller.
// Counts minutes 00..59 in BCD from a once-per-minute tick and issues a
// one-cycle hour-advance pulse on each 59->00 wrap. In set mode the minute
// count is frozen; debounced buttons step the minutes or request an hour
// advance, and a blink enable toggles for the display.
//
// Ports:
//   maqh_clock     system clock, rising edge
//   reset          asynchronous, active-low reset
//   maqm_tick      one-cycle minute tick from the seconds stage
//   maqm_set_en    raw slide switch, 1 = set mode
//   maqm_btn_min   raw push-button, step minutes (set mode only)
//   maqm_btn_hora  raw push-button, advance hour (set mode only)
//   maqm_lsd       minute units, BCD 0..9
//   maqm_msd       minute tens, 0..5
//   maqm_inc_hora  one-cycle hour-advance pulse to the hour stage
//   maqm_set_mode  1 while in SET
//   maqm_blink     display blink enable, toggles in SET, 0 in RUN
module maq_m_set #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned BLINK_CYCLES = 8
) (
  input  logic       maqh_clock,
  input  logic       reset,
  input  logic       maqm_tick,
  input  logic       maqm_set_en,
  input  logic       maqm_btn_min,
  input  logic       maqm_btn_hora,
  output logic [3:0] maqm_lsd,
  output logic [2:0] maqm_msd,
  output logic       maqm_inc_hora,
  output logic       maqm_set_mode,
  output logic       maqm_blink
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  // Button vectors: bit 0 = btn_min, bit 1 = btn_hora.
  logic       set_s1, set_s2;
  logic [1:0] btn_s1, btn_s2;
  logic [1:0] deb, deb_q, press;
  logic [15:0] deb_cnt [2];
  logic [15:0] blink_cnt;
  logic [0:0]  state;

  logic [3:0] lsd_inc;
  logic [2:0] msd_inc;
  logic       wrap;
  logic       run_tick, min_step, hora_req, illegal;
  logic [3:0] lsd_nxt;
  logic [2:0] msd_nxt;
  logic       inc_nxt;

  assign maqm_set_mode = (state == ST_SET);

  // Synchronisers, debouncers and press-edge detectors.
  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) begin
      set_s1 <= 1'b0;
      set_s2 <= 1'b0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb    <= '0;
      deb_q  <= '0;
      press  <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      set_s1 <= maqm_set_en;
      set_s2 <= set_s1;
      btn_s1 <= {maqm_btn_hora, maqm_btn_min};
      btn_s2 <= btn_s1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (btn_s2[i] != deb[i]) begin
          // The flip happens on the edge after the count reaches DEB_CYCLES.
          if (deb_cnt[i] == 16'(DEB_CYCLES)) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 16'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      deb_q <= deb;
      press <= deb & ~deb_q;
    end
  end

  // Next-minute arithmetic and action decode, all under the pre-edge state.
  always_comb begin
    lsd_inc = maqm_lsd + 4'd1;
    msd_inc = maqm_msd;
    wrap    = 1'b0;
    if (maqm_lsd == 4'd9) begin
      lsd_inc = '0;
      if (maqm_msd == 3'd5) begin
        msd_inc = '0;
        wrap    = 1'b1;
      end else begin
        msd_inc = maqm_msd + 3'd1;
      end
    end

    run_tick = (state == ST_RUN) && maqm_tick;
    min_step = (state == ST_SET) && press[0];
    hora_req = (state == ST_SET) && press[1];
    illegal  = (maqm_lsd > 4'd9) || (maqm_msd > 3'd5);

    lsd_nxt = maqm_lsd;
    msd_nxt = maqm_msd;
    if (illegal) begin
      lsd_nxt = '0;
      msd_nxt = '0;
    end else if (run_tick || min_step) begin
      lsd_nxt = lsd_inc;
      msd_nxt = msd_inc;
    end

    // Suppressing a request right after a pulse keeps pulses isolated.
    inc_nxt = ((run_tick && wrap && !illegal) || hora_req) && !maqm_inc_hora;
  end

  // Mode FSM, minute digits, hour pulse and blink.
  always_ff @(posedge maqh_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      maqm_lsd      <= '0;
      maqm_msd      <= '0;
      maqm_inc_hora <= 1'b0;
      maqm_blink    <= 1'b0;
      blink_cnt     <= '0;
    end else begin
      state         <= set_s2 ? ST_SET : ST_RUN;
      maqm_lsd      <= lsd_nxt;
      maqm_msd      <= msd_nxt;
      maqm_inc_hora <= inc_nxt;
      // Blink runs only while SET persists; entry and exit both clear it.
      if ((state == ST_SET) && set_s2) begin
        if (blink_cnt == 16'(BLINK_CYCLES - 1)) begin
          blink_cnt  <= '0;
          maqm_blink <= ~maqm_blink;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end else begin
        blink_cnt  <= '0;
        maqm_blink <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maq_m_set.sv
// tb_maq_m_set -- directed/randomised bench for maq_m_set.
// Minutes are modelled as a plain integer 0..59; hour pulses are counted by
// a monitor and compared against expected totals.
module tb_maq_m_set;

  localparam int unsigned DEB   = 4;
  localparam int unsigned BLINK = 8;

  logic       maqh_clock = 1'b0;
  logic       reset;
  logic       maqm_tick, maqm_set_en, maqm_btn_min, maqm_btn_hora;
  logic [3:0] maqm_lsd;
  logic [2:0] maqm_msd;
  logic       maqm_inc_hora, maqm_set_mode, maqm_blink;

  int unsigned nvec = 0;
  int unsigned nmis = 0;
  int unsigned inc_count = 0;
  int unsigned base;
  logic        inc_prev = 1'b0;
  int          m;

  maq_m_set #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
    .maqh_clock   (maqh_clock),
    .reset        (reset),
    .maqm_tick    (maqm_tick),
    .maqm_set_en  (maqm_set_en),
    .maqm_btn_min (maqm_btn_min),
    .maqm_btn_hora(maqm_btn_hora),
    .maqm_lsd     (maqm_lsd),
    .maqm_msd     (maqm_msd),
    .maqm_inc_hora(maqm_inc_hora),
    .maqm_set_mode(maqm_set_mode),
    .maqm_blink   (maqm_blink)
  );

  always #5 maqh_clock = ~maqh_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_digits(input string tag);
    chk(tag, {25'd0, maqm_msd, maqm_lsd}, 32'((m / 10) * 16 + (m % 10)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lsd"},   32'(maqm_lsd), 0);
    chk({tag, "_msd"},   32'(maqm_msd), 0);
    chk({tag, "_inc"},   32'(maqm_inc_hora), 0);
    chk({tag, "_mode"},  32'(maqm_set_mode), 0);
    chk({tag, "_blink"}, 32'(maqm_blink), 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge maqh_clock);
    #1;
  endtask

  task automatic do_tick();
    maqm_tick = 1'b1;
    @(posedge maqh_clock);
    #1;
    maqm_tick = 1'b0;
  endtask

  // One RUN tick: the model advances only when not in SET.
  task automatic run_tick(input string tag);
    do_tick();
    m = (m + 1) % 60;
    chk_digits(tag);
    chk({tag, "_inc"}, 32'(maqm_inc_hora), 32'(m == 0));
  endtask

  // Button press: high sampled at edge 0, action visible after edge DEB+4.
  task automatic press(input bit bmin, input bit bhora, input string tag);
    int unsigned hold;
    hold = DEB + 6 + $urandom_range(0, 4);
    maqm_btn_min  = bmin;
    maqm_btn_hora = bhora;
    idle(DEB + 4);
    chk_digits({tag, "_pre"});
    chk({tag, "_pre_inc"}, 32'(maqm_inc_hora), 0);
    idle(1);
    if (bmin) m = (m + 1) % 60;
    chk_digits({tag, "_act"});
    chk({tag, "_act_inc"}, 32'(maqm_inc_hora), 32'(bhora));
    idle(1);
    chk({tag, "_post_inc"}, 32'(maqm_inc_hora), 0);
    idle(hold - (DEB + 6));
    maqm_btn_min  = 1'b0;
    maqm_btn_hora = 1'b0;
    idle(DEB + 6 + $urandom_range(0, 4));
    chk_digits({tag, "_held"});
  endtask

  // Pulse counter; a pulse must never follow a pulse.
  always @(negedge maqh_clock) begin
    if (reset === 1'b1 && maqm_inc_hora === 1'b1) begin
      inc_count++;
      chk("inc_consecutive", 32'(inc_prev), 0);
    end
    inc_prev = maqm_inc_hora;
  end

  initial begin
    reset = 1'b0;
    maqm_tick = 1'b0;
    maqm_set_en = 1'b0;
    maqm_btn_min = 1'b0;
    maqm_btn_hora = 1'b0;
    m = 0;
    #12;
    chk_all_zero("reset");
    @(negedge maqh_clock) reset = 1'b1;
    idle(1);

    // Count to 37 with random spacing, then reset asynchronously.
    while (m != 37) begin
      idle($urandom_range(0, 3));
      run_tick("count37");
    end
    #2 reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m = 0;
    @(negedge maqh_clock) reset = 1'b1;
    idle(1);
    run_tick("first_tick");

    // Full wrap from 00.
    #2 reset = 1'b0;
    m = 0;
    @(negedge maqh_clock) reset = 1'b1;
    idle(1);
    base = inc_count;
    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(2, 4));
      run_tick("wrap");
    end
    idle(3);
    chk("wrap_inc_count", inc_count - base, 1);

    // Go to 58, then enter SET.
    while (m != 58) begin
      idle($urandom_range(0, 2));
      run_tick("to58");
    end
    maqm_set_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("set_entry", 32'(maqm_set_mode), 32'(i == 3));
    end
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      chk("blink", 32'(maqm_blink), 32'((k / BLINK) % 2));
    end

    base = inc_count;
    do_tick();
    chk_digits("set_tick_frozen");
    for (int i = 0; i < int'($urandom_range(3, 5)); i++) begin
      press(1'b1, 1'b0, "btn_min");
      if ($urandom_range(0, 1) == 1) begin
        do_tick();
        chk_digits("set_tick_frozen");
      end
    end
    chk("min_inc_count", inc_count - base, 0);

    // Short glitch must not qualify.
    maqm_btn_hora = 1'b1;
    idle($urandom_range(1, DEB - 1));
    maqm_btn_hora = 1'b0;
    idle(2 * DEB + 8);
    chk("glitch_inc_count", inc_count - base, 0);

    press(1'b0, 1'b1, "btn_hora");
    chk("hora_inc_count", inc_count - base, 1);
    press(1'b1, 1'b1, "btn_both");
    chk("both_inc_count", inc_count - base, 2);

    // Exit SET: tick on the transition edge dropped, next one counted.
    maqm_set_en = 1'b0;
    idle(2);
    chk("exit_mode_hold", 32'(maqm_set_mode), 1);
    do_tick();
    chk("exit_mode", 32'(maqm_set_mode), 0);
    chk("exit_blink", 32'(maqm_blink), 0);
    chk_digits("exit_tick_dropped");
    run_tick("exit_tick_counted");
    idle(2);
    chk("final_blink", 32'(maqm_blink), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
